// File: rtl/ntt_pkg.sv
// Shared constants and FSM encoding for the NTT stage address generator.
// Fixed 1024-point transform: 4 radix-2 butterflies (8 coefficient lanes) per cycle.
package ntt_pkg;
   localparam int LOG_N         = 10;
   localparam int N             = 1 << LOG_N;
   localparam int LANES         = 8;
   localparam int BFLY_PER_CYC  = 4;
   localparam int CYC_PER_STAGE = N / (2 * BFLY_PER_CYC);
   localparam int LAST_STEP     = LOG_N - 1;

   typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;
endpackage

// File: rtl/ntt_bfly_addr_calc.sv
// Combinational butterfly address/twiddle calculator: inserts a 0 at bit s of b for the
// top address, sets it for the bottom, and scales the low s bits into a twiddle index.
module ntt_bfly_addr_calc
   import ntt_pkg::*;
(
   input  logic [LOG_N-2:0] b,
   input  logic [3:0]       s,
   output logic [LOG_N-1:0] a0,
   output logic [LOG_N-1:0] a1,
   output logic [LOG_N-2:0] tw
);
   logic [LOG_N-1:0] bw;
   logic [LOG_N-1:0] h;
   logic [LOG_N-1:0] mask;
   logic [LOG_N-1:0] hi;
   logic [LOG_N-1:0] tw_wide;

   always_comb begin
      bw      = {1'b0, b};
      h       = LOG_N'(1) << s;
      mask    = h - LOG_N'(1);
      hi      = (bw >> s) << (s + 4'd1);
      a0      = hi | (bw & mask);
      a1      = a0 | h;
      // low s bits are below h, so shifting by (9 - s) always lands within 9 bits
      tw_wide = (bw & mask) << (4'(LOG_N - 1) - s);
      tw      = tw_wide[LOG_N-2:0];
   end
endmodule

// File: rtl/ntt_stage_address_gen.sv
// Walks all NTT stages issuing 8 addresses + 4 twiddles per cycle; outputs registered, 1 cycle after issue.
// hold freezes issue (addr_valid drops, outputs keep last vector); the inter-stage bubble ignores hold.
module ntt_stage_address_gen #(
   parameter int LOG_N      = 10,
   parameter int GAP_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic             hold,
   output logic             busy,
   output logic             addr_valid,
   output logic [LOG_N-1:0] old_address_0,
   output logic [LOG_N-1:0] old_address_1,
   output logic [LOG_N-1:0] old_address_2,
   output logic [LOG_N-1:0] old_address_3,
   output logic [LOG_N-1:0] old_address_4,
   output logic [LOG_N-1:0] old_address_5,
   output logic [LOG_N-1:0] old_address_6,
   output logic [LOG_N-1:0] old_address_7,
   output logic [LOG_N-2:0] twiddle_idx_0,
   output logic [LOG_N-2:0] twiddle_idx_1,
   output logic [LOG_N-2:0] twiddle_idx_2,
   output logic [LOG_N-2:0] twiddle_idx_3,
   output logic [3:0]       stage,
   output logic             stage_last,
   output logic             done
);
   import ntt_pkg::*;

   localparam int         GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [6:0] LAST_CNT = 7'(CYC_PER_STAGE - 1);

   state_t          state, state_nx;
   logic [3:0]      step, step_nx;
   logic [6:0]      cnt, cnt_nx;
   logic [GW-1:0]   gap_cnt, gap_nx;
   logic            mode_q, mode_nx;
   logic            issue;
   logic [3:0]      s_eff;

   logic [LOG_N-1:0] addr_nx [LANES];
   logic [LOG_N-2:0] tw_nx   [BFLY_PER_CYC];
   logic [LOG_N-1:0] addr_q  [LANES];
   logic [LOG_N-2:0] tw_q    [BFLY_PER_CYC];

   always_comb begin
      state_nx = state;
      step_nx  = step;
      cnt_nx   = cnt;
      gap_nx   = gap_cnt;
      mode_nx  = mode_q;
      issue    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = RUN;
               mode_nx  = mode;
               step_nx  = '0;
               cnt_nx   = '0;
            end
         end
         RUN: begin
            if (!hold) begin
               issue  = 1'b1;
               cnt_nx = cnt + 7'd1;
               if (cnt == LAST_CNT) begin
                  if (step == 4'(LAST_STEP)) begin
                     state_nx = DONE;
                  end else if (GAP_CYCLES == 0) begin
                     step_nx = step + 4'd1;
                  end else begin
                     state_nx = GAP;
                     gap_nx   = GW'(GAP_CYCLES - 1);
                  end
               end
            end
         end
         GAP: begin
            if (gap_cnt == '0) begin
               state_nx = RUN;
               step_nx  = step + 4'd1;
            end else begin
               gap_nx = gap_cnt - GW'(1);
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      s_eff = mode_q ? (4'(LAST_STEP) - step) : step;
   end

   for (genvar k = 0; k < BFLY_PER_CYC; k++) begin : g_bfly
      ntt_bfly_addr_calc u_calc (
         .b  ({cnt, 2'(k)}),
         .s  (s_eff),
         .a0 (addr_nx[2*k]),
         .a1 (addr_nx[2*k+1]),
         .tw (tw_nx[k])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         step       <= '0;
         cnt        <= '0;
         gap_cnt    <= '0;
         mode_q     <= 1'b0;
         busy       <= 1'b0;
         addr_valid <= 1'b0;
         stage      <= '0;
         stage_last <= 1'b0;
         done       <= 1'b0;
         for (int i = 0; i < LANES; i++) addr_q[i] <= '0;
         for (int i = 0; i < BFLY_PER_CYC; i++) tw_q[i] <= '0;
      end else begin
         state      <= state_nx;
         step       <= step_nx;
         cnt        <= cnt_nx;
         gap_cnt    <= gap_nx;
         mode_q     <= mode_nx;
         // busy stays up through the done pulse, which is emitted while leaving DONE
         busy       <= (state_nx != IDLE) || (state == DONE);
         addr_valid <= issue;
         stage_last <= issue && (cnt == LAST_CNT);
         done       <= (state == DONE);
         if (issue) begin
            stage  <= s_eff;
            addr_q <= addr_nx;
            tw_q   <= tw_nx;
         end
      end
   end

   assign old_address_0 = addr_q[0];
   assign old_address_1 = addr_q[1];
   assign old_address_2 = addr_q[2];
   assign old_address_3 = addr_q[3];
   assign old_address_4 = addr_q[4];
   assign old_address_5 = addr_q[5];
   assign old_address_6 = addr_q[6];
   assign old_address_7 = addr_q[7];
   assign twiddle_idx_0 = tw_q[0];
   assign twiddle_idx_1 = tw_q[1];
   assign twiddle_idx_2 = tw_q[2];
   assign twiddle_idx_3 = tw_q[3];
endmodule

// File: tb/tb_ntt_stage_address_gen.sv
// Directed bench for ntt_stage_address_gen: vector table with hand-computed addresses,
// plus hold, mid-run reset and per-stage address coverage scoreboard.
module tb_ntt_stage_address_gen;
   logic clk = 1'b0;
   logic rst, start, mode, hold;
   logic busy, addr_valid, stage_last, done;
   logic [9:0] oa0, oa1, oa2, oa3, oa4, oa5, oa6, oa7;
   logic [8:0] tw0, tw1, tw2, tw3;
   logic [3:0] stage;

   always #5 clk = ~clk;

   ntt_stage_address_gen #(.LOG_N(10), .GAP_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .hold(hold),
      .busy(busy), .addr_valid(addr_valid),
      .old_address_0(oa0), .old_address_1(oa1), .old_address_2(oa2), .old_address_3(oa3),
      .old_address_4(oa4), .old_address_5(oa5), .old_address_6(oa6), .old_address_7(oa7),
      .twiddle_idx_0(tw0), .twiddle_idx_1(tw1), .twiddle_idx_2(tw2), .twiddle_idx_3(tw3),
      .stage(stage), .stage_last(stage_last), .done(done)
   );

   logic [7:0][9:0] cur_a;
   logic [3:0][8:0] cur_t;
   assign cur_a = {oa7, oa6, oa5, oa4, oa3, oa2, oa1, oa0};
   assign cur_t = {tw3, tw2, tw1, tw0};

   typedef struct packed {
      logic [7:0][9:0] a;
      logic [3:0][8:0] t;
      logic [3:0]      st;
      int              rel;
   } rec_t;

   typedef struct packed {
      logic            m;
      int              idx;
      int              cyc;
      int              st;
      logic [7:0][9:0] a;
      logic [3:0][8:0] t;
   } vec_t;

   rec_t rec [1280];
   vec_t tbl [9];

   int tests = 0, fails = 0;
   int cyc = 0, t0 = 0, mrel = 0;
   bit mon_en = 1'b0;
   int nvec, done_cnt, done_rel, busy_cnt, busy_first, busy_last, dup, last_bad;
   int last_cnt [10];
   bit seen [10][1024];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic m, input int idx, input int cy, input int st,
                               input int a0, input int a1, input int a2, input int a3,
                               input int a4, input int a5, input int a6, input int a7,
                               input int w0, input int w1, input int w2, input int w3);
      vec_t v;
      v.m = m; v.idx = idx; v.cyc = cy; v.st = st;
      v.a[0] = 10'(a0); v.a[1] = 10'(a1); v.a[2] = 10'(a2); v.a[3] = 10'(a3);
      v.a[4] = 10'(a4); v.a[5] = 10'(a5); v.a[6] = 10'(a6); v.a[7] = 10'(a7);
      v.t[0] = 9'(w0); v.t[1] = 9'(w1); v.t[2] = 9'(w2); v.t[3] = 9'(w3);
      return v;
   endfunction

   // passive monitor, sampling away from the active edge
   always @(negedge clk) begin
      if (mon_en) begin
         mrel = cyc - t0;
         if (busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = mrel;
            busy_last = mrel;
         end
         if (done) begin
            done_cnt++;
            done_rel = mrel;
         end
         if (addr_valid) begin
            if (nvec < 1280) begin
               rec[nvec].a   = cur_a;
               rec[nvec].t   = cur_t;
               rec[nvec].st  = stage;
               rec[nvec].rel = mrel;
            end
            if (stage_last !== ((nvec % 128) == 127)) last_bad++;
            if (stage < 10) begin
               if (stage_last) last_cnt[stage]++;
               for (int k = 0; k < 8; k++) begin
                  if (seen[stage][cur_a[k]]) dup++;
                  seen[stage][cur_a[k]] = 1'b1;
               end
            end
            nvec++;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_mon();
      nvec = 0; done_cnt = 0; done_rel = -1; busy_cnt = 0;
      busy_first = -1; busy_last = -1; dup = 0; last_bad = 0;
      for (int s = 0; s < 10; s++) begin
         last_cnt[s] = 0;
         for (int a = 0; a < 1024; a++) seen[s][a] = 1'b0;
      end
   endtask

   task automatic start_run(input logic m);
      clear_mon();
      start = 1'b1;
      mode  = m;
      t0    = cyc;
      mon_en = 1'b1;
      tick();
      start = 1'b0;
      mode  = 1'b0;
   endtask

   task automatic wait_vec(input int n);
      int guard;
      guard = 0;
      while (nvec < n && guard < 3000) begin
         tick();
         guard++;
      end
      chk("wait_vec_timeout", (nvec >= n) ? 1 : 0, 1);
   endtask

   task automatic wait_done(input string tag, input int exp_done);
      int guard, cov_bad, lst_bad, c;
      guard = 0;
      while (done_cnt == 0 && guard < 3000) begin
         tick();
         guard++;
      end
      chk({tag, "_done_seen"}, (done_cnt > 0) ? 1 : 0, 1);
      repeat (3) tick();
      mon_en = 1'b0;
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_done_cycle"}, done_rel, exp_done);
      chk({tag, "_busy_first"}, busy_first, 1);
      chk({tag, "_busy_last"}, busy_last, exp_done);
      chk({tag, "_busy_cycles"}, busy_cnt, exp_done);
      chk({tag, "_vectors"}, nvec, 1280);
      chk({tag, "_dup_addr"}, dup, 0);
      chk({tag, "_stage_last_pos"}, last_bad, 0);
      cov_bad = 0;
      lst_bad = 0;
      for (int s = 0; s < 10; s++) begin
         c = 0;
         for (int a = 0; a < 1024; a++) c += int'(seen[s][a]);
         if (c != 1024) cov_bad++;
         if (last_cnt[s] != 1) lst_bad++;
      end
      chk({tag, "_stages_missing_addr"}, cov_bad, 0);
      chk({tag, "_stage_last_count_bad"}, lst_bad, 0);
      chk({tag, "_busy_after"}, int'(busy), 0);
      chk({tag, "_valid_after"}, int'(addr_valid), 0);
   endtask

   task automatic check_table(input logic m);
      int idx;
      for (int i = 0; i < 9; i++) begin
         if (tbl[i].m == m) begin
            idx = tbl[i].idx;
            chk($sformatf("m%0d_v%0d_cycle", m, idx), rec[idx].rel, tbl[i].cyc);
            chk($sformatf("m%0d_v%0d_stage", m, idx), int'(rec[idx].st), tbl[i].st);
            for (int k = 0; k < 8; k++)
               chk($sformatf("m%0d_v%0d_addr%0d", m, idx, k), int'(rec[idx].a[k]), int'(tbl[i].a[k]));
            for (int k = 0; k < 4; k++)
               chk($sformatf("m%0d_v%0d_tw%0d", m, idx, k), int'(rec[idx].t[k]), int'(tbl[i].t[k]));
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_valid"}, int'(addr_valid), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_stage"}, int'(stage), 0);
      chk({tag, "_stage_last"}, int'(stage_last), 0);
      chk({tag, "_addr_nonzero"}, (cur_a == '0) ? 0 : 1, 0);
      chk({tag, "_tw_nonzero"}, (cur_t == '0) ? 0 : 1, 0);
   endtask

   initial begin
      logic [7:0][9:0] cap_a;
      logic [3:0][8:0] cap_t;
      logic [3:0]      cap_s;

      //      m  idx   cyc   st  addresses lanes 0..7                               twiddles 0..3
      tbl[0] = mk(0, 0,    2,    0, 0, 1, 2, 3, 4, 5, 6, 7,                         0, 0, 0, 0);
      tbl[1] = mk(0, 127,  129,  0, 1016, 1017, 1018, 1019, 1020, 1021, 1022, 1023, 0, 0, 0, 0);
      tbl[2] = mk(0, 128,  134,  1, 0, 2, 1, 3, 4, 6, 5, 7,                         0, 256, 0, 256);
      tbl[3] = mk(0, 385,  399,  3, 4, 12, 5, 13, 6, 14, 7, 15,                     256, 320, 384, 448);
      tbl[4] = mk(0, 650,  672,  5, 72, 104, 73, 105, 74, 106, 75, 107,             128, 144, 160, 176);
      tbl[5] = mk(0, 1279, 1317, 9, 508, 1020, 509, 1021, 510, 1022, 511, 1023,     508, 509, 510, 511);
      tbl[6] = mk(1, 0,    2,    9, 0, 512, 1, 513, 2, 514, 3, 515,                 0, 1, 2, 3);
      tbl[7] = mk(1, 133,  139,  8, 20, 276, 21, 277, 22, 278, 23, 279,             40, 42, 44, 46);
      tbl[8] = mk(1, 1279, 1317, 0, 1016, 1017, 1018, 1019, 1020, 1021, 1022, 1023, 0, 0, 0, 0);

      // reset with start held high: start must be ignored
      rst = 1'b1; start = 1'b1; mode = 1'b0; hold = 1'b0;
      repeat (3) tick();
      chk_all_zero("reset");
      rst = 1'b0; start = 1'b0;
      repeat (2) tick();
      chk("idle_after_reset_busy", int'(busy), 0);
      chk("idle_after_reset_valid", int'(addr_valid), 0);

      // inverse-order transform, no stalls
      start_run(1'b1);
      wait_done("inv", 1318);
      check_table(1'b1);

      // forward transform with a second start and a 5-cycle hold inside stage 2
      start_run(1'b0);
      wait_vec(2*128 + 30);
      start = 1'b1; mode = 1'b1;
      tick();
      start = 1'b0; mode = 1'b0;
      tick();
      chk("pre_hold_valid", int'(addr_valid), 1);
      cap_a = cur_a; cap_t = cur_t; cap_s = stage;
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("hold%0d_valid", i), int'(addr_valid), 0);
         chk($sformatf("hold%0d_frozen", i),
             (cur_a == cap_a && cur_t == cap_t && stage == cap_s) ? 1 : 0, 1);
      end
      hold = 1'b0;
      tick();
      chk("post_hold_valid", int'(addr_valid), 1);
      wait_done("hold", 1323);
      chk("hold_run_first_stage", int'(rec[0].st), 0);
      chk("hold_run_last_stage", int'(rec[1279].st), 9);

      // abort mid stage 5, then replay a clean forward run
      start_run(1'b0);
      wait_vec(5*128 + 10);
      rst = 1'b1;
      tick();
      chk_all_zero("abort");
      rst = 1'b0;
      mon_en = 1'b0;
      repeat (3) tick();
      chk("abort_idle_busy", int'(busy), 0);
      chk("abort_idle_valid", int'(addr_valid), 0);
      start_run(1'b0);
      wait_done("fwd", 1318);
      check_table(1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
